fir_out_fifo: RTL and testbench

- Elastic output buffer directly downstream of the FIR filter (myfir).
- Captures every filtered sample strobed by the filter's output valid. The filter has no backpressure, so the buffer accepts or drops each sample in its cycle.
- Delivers samples to the consumer (data sink or next stage) over a valid/ready handshake.
- Reports fill level, full status and a sticky overflow flag for drop detection.

---
 rtl/fir_pkg.sv | 10 +
 rtl/fir_fifo_mem.sv | 25 ++
 rtl/fir_out_fifo.sv | 89 ++++++++
 tb/tb_fir_out_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR sample path.
// Used by myfir, the output FIFO and the data maker/sink.
package fir_pkg;

  localparam int NB         = 9;
  localparam int FIFO_DEPTH = 8;

  typedef logic [NB-1:0] sample_t;

endpackage

// File: rtl/fir_fifo_mem.sv
// Sample storage for the FIR output FIFO.
// One synchronous write port, one asynchronous read port.
module fir_fifo_mem #(
  parameter int NB    = fir_pkg::NB,
  parameter int DEPTH = fir_pkg::FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [NB-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [NB-1:0] rdata
);

  logic [NB-1:0] mem [DEPTH];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_out_fifo.sv
// Elastic first-word-fall-through buffer behind the FIR.
// The filter cannot stall, so overflow drops and is flagged.
module fir_out_fifo #(
  parameter int NB    = fir_pkg::NB,
  parameter int DEPTH = fir_pkg::FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  output logic [NB-1:0] DOUT,
  output logic          VOUT,
  input  logic          RDY,
  output logic [AW:0]   CNT,
  output logic          FULL,
  output logic          OVF,
  input  logic          CLR_OVF
);

  import fir_pkg::*;

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic [AW:0]   cnt;
  logic          ovf;
  logic [NB-1:0] rdata;
  logic          pop;
  logic          push;
  logic          drop;

  // Flags come only from registered count.
  assign VOUT = (cnt != '0);
  assign FULL = (cnt == CNT_MAX);
  assign CNT  = cnt;
  assign OVF  = ovf;
  assign DOUT = VOUT ? rdata : '0;

  assign pop  = VOUT & RDY;
  assign push = VIN & (~FULL | pop);
  assign drop = VIN & FULL & ~pop;

  fir_fifo_mem #(
    .NB    (NB),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (wr),
    .wdata (DIN),
    .raddr (rd),
    .rdata (rdata)
  );

  // Pointers advance on push/pop with natural wrap.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop)  rd <= rd + 1'b1;
    end
  end

  // Count is the single source of empty/full.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow; a drop beats a clear.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)       ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (CLR_OVF) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_fir_out_fifo.sv
// Self-checking bench for fir_out_fifo.
// Queue-based reference model, directed plus random steps.
module tb_fir_out_fifo;

  import fir_pkg::*;

  localparam int D = 8;

  logic       CLK;
  logic       RST_n;
  logic [8:0] DIN;
  logic       VIN;
  logic [8:0] DOUT;
  logic       VOUT;
  logic       RDY;
  logic [3:0] CNT;
  logic       FULL;
  logic       OVF;
  logic       CLR_OVF;

  int tests;
  int fails;

  sample_t q[$];
  bit      m_ovf;
  int      max_cnt;

  fir_out_fifo #(
    .NB    (9),
    .DEPTH (D),
    .AW    (3)
  ) dut (
    .CLK     (CLK),
    .RST_n   (RST_n),
    .DIN     (DIN),
    .VIN     (VIN),
    .DOUT    (DOUT),
    .VOUT    (VOUT),
    .RDY     (RDY),
    .CNT     (CNT),
    .FULL    (FULL),
    .OVF     (OVF),
    .CLR_OVF (CLR_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    sample_t hd;
    hd = (q.size() != 0) ? q[0] : 9'h000;
    chk({tag, ".cnt"},  16'(CNT),  16'(q.size()));
    chk({tag, ".vout"}, 16'(VOUT), 16'(q.size() != 0));
    chk({tag, ".full"}, 16'(FULL), 16'(q.size() == D));
    chk({tag, ".dout"}, 16'(DOUT), 16'(hd));
    chk({tag, ".ovf"},  16'(OVF),  16'(m_ovf));
  endtask

  // One clock: drive, update model at the edge, check after it.
  task automatic step(input string tag, input bit vin,
                      input sample_t din, input bit rdy,
                      input bit clr);
    int  n;
    bit  do_pop;
    bit  drop;
    VIN     = vin;
    DIN     = din;
    RDY     = rdy;
    CLR_OVF = clr;
    n       = q.size();
    do_pop  = rdy && n > 0;
    drop    = vin && n == D && !do_pop;
    @(posedge CLK);
    #1;
    if (do_pop) void'(q.pop_front());
    if (vin && !drop) q.push_back(din);
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (q.size() > max_cnt) max_cnt = q.size();
    VIN     = 0;
    RDY     = 0;
    CLR_OVF = 0;
    chk_all(tag);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    m_ovf   = 0;
    RST_n   = 0;
    VIN     = 0;
    DIN     = '0;
    RDY     = 0;
    CLR_OVF = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk_all("reset");
    @(negedge CLK);
    RST_n = 1;
    @(posedge CLK);
    #1;

    // 1: three pushes, hold, then drain
    for (int i = 1; i <= 3; i++) step("t1push", 1, 9'(i), 0, 0);
    step("t1hold", 0, '0, 0, 0);
    chk("t1.dout_const", 16'(DOUT), 16'h001);
    chk("t1.cnt_const", 16'(CNT), 16'd3);
    for (int i = 0; i < 3; i++) step("t1pop", 0, '0, 1, 0);
    chk("t1.empty", 16'(VOUT), 16'd0);

    // 2: fill, drop 0x1FF, drain in order
    for (int i = 0; i < 8; i++) step("t2fill", 1, 9'h100 + 9'(i), 0, 0);
    chk("t2.full_const", 16'(FULL), 16'd1);
    step("t2drop", 1, 9'h1FF, 0, 0);
    chk("t2.ovf_const", 16'(OVF), 16'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t2.drain_const", 16'(DOUT), 16'h100 + 16'(i));
      step("t2drain", 0, '0, 1, 0);
    end

    // 3: full with simultaneous push and pop
    step("t3clr", 0, '0, 0, 1);
    for (int i = 0; i < 8; i++) step("t3fill", 1, 9'h100 + 9'(i), 0, 0);
    step("t3pp", 1, 9'h0AA, 1, 0);
    chk("t3.cnt_const", 16'(CNT), 16'd8);
    chk("t3.head_const", 16'(DOUT), 16'h101);
    for (int i = 0; i < 8; i++) step("t3drain", 0, '0, 1, 0);

    // 4: streaming ramp across pointer wraps
    max_cnt = 0;
    for (int i = 0; i <= 20; i++) step("t4ramp", 1, 9'(i), 1, 0);
    chk("t4.maxcnt", 16'(max_cnt), 16'd1);
    step("t4last", 0, '0, 1, 0);

    // 5: drop and clear together, then clear alone
    for (int i = 0; i < 8; i++) step("t5fill", 1, 9'(i + 50), 0, 0);
    step("t5drop", 1, 9'h033, 0, 0);
    step("t5both", 1, 9'h044, 0, 1);
    chk("t5.ovf_set_wins", 16'(OVF), 16'd1);
    step("t5clr", 0, '0, 0, 1);
    chk("t5.ovf_cleared", 16'(OVF), 16'd0);
    for (int i = 0; i < 8; i++) step("t5drain", 0, '0, 1, 0);

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step("t6fill", 1, 9'(i + 7), 0, 0);
    step("t6drop_prep", 0, '0, 0, 0);
    #3;
    RST_n = 0;
    #1;
    q.delete();
    m_ovf = 0;
    chk_all("t6async");
    @(negedge CLK);
    RST_n = 1;
    @(posedge CLK);
    #1;
    step("t6push", 1, 9'h055, 0, 0);
    chk("t6.dout_const", 16'(DOUT), 16'h055);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rand",
           bit'($urandom_range(0, 99) < 60),
           9'($urandom),
           bit'($urandom_range(0, 99) < 45),
           bit'($urandom_range(0, 99) < 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
